lcd_serial_rx: RTL

Serial receiver for the three-wire LCD bus (SCK, SDA, active-low CS) driven by the bit-banged PIO outputs. It oversamples the bus on the system clock, assembles MSB-first words, and buffers them in a small FIFO. The FIFO is readable by the Nios II through an Avalon-MM slave. Its uses are loopback and self-test of the LCD driver firmware, and modelling of the panel in system simulation.

---
 rtl/lcd_serial_rx.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lcd_serial_rx.sv
// Three-wire LCD bus receiver: oversampled SCK/SDA/CS_N, MSB-first word assembly, FIFO readable over Avalon-MM.
// Define LCD_RX_IRQ_EN to add the IRQ_EN control bit and the registered irq output.
module lcd_serial_rx #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [7:0]  writedata,
    output logic [15:0] readdata,
    input  logic        sck_in,
    input  logic        sda_in,
    input  logic        cs_n_in
`ifdef LCD_RX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [2:0] sckSync_q, sdaSync_q, csSync_q;
    logic       sckRise_q, csFall_q, csRise_q, csLow_q, sdaBit_q;

    logic [CW-1:0]     bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, shiftNext;
    logic              lastBit, push;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wrPtr_q, rdPtr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              full, pop, accept, ctrlWr;
    logic              overrun_q, overrun_d, frameErr_q, frameErr_d;
    logic              irqEn;

    // Bits [1] are the synchronized lines, bits [2] the previous value; edge pulses are registered once more
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sckSync_q <= 3'b000;
            sdaSync_q <= 3'b000;
            csSync_q  <= 3'b111;
            sckRise_q <= 1'b0;
            csFall_q  <= 1'b0;
            csRise_q  <= 1'b0;
            csLow_q   <= 1'b0;
            sdaBit_q  <= 1'b0;
        end else begin
            sckSync_q <= {sckSync_q[1:0], sck_in};
            sdaSync_q <= {sdaSync_q[1:0], sda_in};
            csSync_q  <= {csSync_q[1:0], cs_n_in};
            sckRise_q <= sckSync_q[1] & ~sckSync_q[2];
            csFall_q  <= ~csSync_q[1] & csSync_q[2];
            csRise_q  <= csSync_q[1] & ~csSync_q[2];
            csLow_q   <= ~csSync_q[1];
            sdaBit_q  <= sdaSync_q[1];
        end
    end

    assign lastBit   = (bitCnt_q == CW'(DATA_W - 1));
    assign shiftNext = (shift_q << 1) | DATA_W'(sdaBit_q);
    assign push      = sckRise_q & csLow_q & lastBit;

    always_comb begin
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        if (csFall_q) begin
            bitCnt_d = '0;
            shift_d  = '0;
        end else if (csRise_q) begin
            bitCnt_d = '0;
        end else if (sckRise_q && csLow_q) begin
            shift_d  = shiftNext;
            bitCnt_d = lastBit ? '0 : bitCnt_q + CW'(1);
        end
    end

    assign full   = (level_q == LW'(FIFO_DEPTH));
    assign pop    = chipselect & ~read_n & (address == 2'd0) & (level_q != '0);
    assign accept = push & (~full | pop);
    assign ctrlWr = chipselect & ~write_n & (address == 2'd2);

    // A set in the same cycle as a clear wins
    always_comb begin
        level_d = level_q;
        case ({accept, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        overrun_d  = (push & full & ~pop) | (overrun_q & ~(ctrlWr & writedata[2]));
        frameErr_d = (csRise_q & (bitCnt_q != '0)) | (frameErr_q & ~(ctrlWr & writedata[3]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitCnt_q   <= '0;
            shift_q    <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            level_q    <= level_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
            if (accept) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)    rdPtr_q <= rdPtr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wrPtr_q] <= shiftNext;
    end

`ifdef LCD_RX_IRQ_EN
    logic irqEn_q, irqEn_d, irq_q;

    assign irqEn_d = ctrlWr ? writedata[0] : irqEn_q;

    // irq follows next-state flags so it rises on the same edge the word lands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqEn_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqEn_q <= irqEn_d;
            irq_q   <= irqEn_d & ((level_d != '0) | overrun_d | frameErr_d);
        end
    end

    assign irqEn = irqEn_q;
    assign irq   = irq_q;

    logic unusedWriteBits;
    assign unusedWriteBits = ^{writedata[7:4], writedata[1]};
`else
    assign irqEn = 1'b0;

    logic unusedWriteBits;
    assign unusedWriteBits = ^{writedata[7:4], writedata[1:0]};
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: if (level_q != '0) readdata = 16'(mem_q[rdPtr_q]);
            2'd1: begin
                readdata[0]    = (level_q != '0);
                readdata[1]    = full;
                readdata[2]    = overrun_q;
                readdata[3]    = frameErr_q;
                readdata[4]    = irqEn;
                readdata[12:8] = 5'(level_q);
            end
            default: readdata = '0;
        endcase
    end

endmodule
